// File: rtl/ps2_scan_ctrl_if.sv
// Byte-FIFO pop handshake and key-event valid/ready bundle for ps2_scan_ctrl.
interface ps2_scan_ctrl_if;
   logic [7:0] kbd_data;
   logic       kbd_ready;
   logic       kbd_overflow;
   logic       kbd_nextdata_n;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_brk;
   logic       evt_ext;

   modport master (
      input  kbd_data, kbd_ready, kbd_overflow, evt_ready,
      output kbd_nextdata_n, evt_valid, evt_code, evt_brk, evt_ext
   );

   modport slave (
      output kbd_data, kbd_ready, kbd_overflow, evt_ready,
      input  kbd_nextdata_n, evt_valid, evt_code, evt_brk, evt_ext
   );
endinterface

// File: rtl/ps2_scan_ctrl.sv
// Pops PS/2 scan bytes, folds E0/F0 prefixes into key events, tracks Shift/Ctrl.
// Optional auto-repeat suppression: define PS2_SCAN_TYPEMATIC_FILTER_EN.
module ps2_scan_ctrl #(
   parameter logic [7:0] SHIFT_L   = 8'h12,
   parameter logic [7:0] SHIFT_R   = 8'h59,
   parameter logic [7:0] CTRL_CODE = 8'h14
) (
   input  logic                  clk,
   input  logic                  rst,
   ps2_scan_ctrl_if.master       bus,
   output logic                  shift_flag,
   output logic                  ctrl_flag,
   output logic [7:0]            press_cnt,
   output logic                  ovf_sticky
);

   localparam int unsigned CODE_W = 8;
   localparam logic [CODE_W-1:0] PFX_EXT = CODE_W'(8'hE0);
   localparam logic [CODE_W-1:0] PFX_BRK = CODE_W'(8'hF0);

   typedef enum logic [1:0] {IDLE, POP, GAP, EMIT} state_t;

   state_t            state;
   logic [CODE_W-1:0] scan_q;
   logic              ext_pend, brk_pend;
   logic              lshift, rshift, lctrl, rctrl;

   logic              is_ext_c, is_brk_c, decode_c, drop_c;
   logic              ev_ext_c, ev_brk_c;
   logic              lshift_c, rshift_c, lctrl_c, rctrl_c;

`ifdef PS2_SCAN_TYPEMATIC_FILTER_EN
   logic              held_vld;
   logic              held_ext;
   logic [CODE_W-1:0] held_code;
   logic              held_match_c;
`endif

   // Decode of the latched byte; an overflow on the same edge discards any pending prefix
   always_comb begin
      is_ext_c = (scan_q == PFX_EXT);
      is_brk_c = (scan_q == PFX_BRK);
      decode_c = (state == GAP) && !is_ext_c && !is_brk_c;
      ev_ext_c = ext_pend & ~bus.kbd_overflow;
      ev_brk_c = brk_pend & ~bus.kbd_overflow;
      drop_c   = 1'b0;
`ifdef PS2_SCAN_TYPEMATIC_FILTER_EN
      held_match_c = held_vld && (held_ext == ev_ext_c) && (held_code == scan_q);
      drop_c       = decode_c && !ev_brk_c && held_match_c;
`endif
      lshift_c = lshift;
      rshift_c = rshift;
      lctrl_c  = lctrl;
      rctrl_c  = rctrl;
      if (decode_c) begin
         if (!ev_ext_c && scan_q == SHIFT_L) lshift_c = ~ev_brk_c;
         if (!ev_ext_c && scan_q == SHIFT_R) rshift_c = ~ev_brk_c;
         if (scan_q == CTRL_CODE) begin
            if (ev_ext_c) rctrl_c = ~ev_brk_c;
            else          lctrl_c = ~ev_brk_c;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         scan_q             <= '0;
         ext_pend           <= 1'b0;
         brk_pend           <= 1'b0;
         lshift             <= 1'b0;
         rshift             <= 1'b0;
         lctrl              <= 1'b0;
         rctrl              <= 1'b0;
         shift_flag         <= 1'b0;
         ctrl_flag          <= 1'b0;
         press_cnt          <= '0;
         ovf_sticky         <= 1'b0;
         bus.kbd_nextdata_n <= 1'b1;
         bus.evt_valid      <= 1'b0;
         bus.evt_code       <= '0;
         bus.evt_brk        <= 1'b0;
         bus.evt_ext        <= 1'b0;
`ifdef PS2_SCAN_TYPEMATIC_FILTER_EN
         held_vld           <= 1'b0;
         held_ext           <= 1'b0;
         held_code          <= '0;
`endif
      end else begin
         lshift     <= lshift_c;
         rshift     <= rshift_c;
         lctrl      <= lctrl_c;
         rctrl      <= rctrl_c;
         shift_flag <= lshift_c | rshift_c;
         ctrl_flag  <= lctrl_c | rctrl_c;

         case (state)
            IDLE: begin
               if (bus.kbd_ready) begin
                  scan_q             <= bus.kbd_data;
                  bus.kbd_nextdata_n <= 1'b0;
                  state              <= POP;
               end
            end
            POP: begin
               bus.kbd_nextdata_n <= 1'b1;
               state              <= GAP;
            end
            GAP: begin
               if (is_ext_c) begin
                  ext_pend <= 1'b1;
                  state    <= IDLE;
               end else if (is_brk_c) begin
                  brk_pend <= 1'b1;
                  state    <= IDLE;
               end else begin
                  ext_pend <= 1'b0;
                  brk_pend <= 1'b0;
                  if (drop_c) begin
                     state <= IDLE;
                  end else begin
                     bus.evt_ext   <= ev_ext_c;
                     bus.evt_brk   <= ev_brk_c;
                     bus.evt_code  <= scan_q;
                     bus.evt_valid <= 1'b1;
                     state         <= EMIT;
                     if (!ev_brk_c) press_cnt <= press_cnt + 8'd1;
                  end
`ifdef PS2_SCAN_TYPEMATIC_FILTER_EN
                  if (!ev_brk_c && !drop_c) begin
                     held_vld  <= 1'b1;
                     held_ext  <= ev_ext_c;
                     held_code <= scan_q;
                  end else if (ev_brk_c && held_match_c) begin
                     held_vld  <= 1'b0;
                  end
`endif
               end
            end
            EMIT: begin
               if (bus.evt_ready) begin
                  bus.evt_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Overflow resynchronises the prefix tracker, overriding any prefix just decoded
         if (bus.kbd_overflow) begin
            ovf_sticky <= 1'b1;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed bench for ps2_scan_ctrl with a small byte-FIFO model on the keyboard side.
module tb_ps2_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       shift_flag, ctrl_flag, ovf_sticky;
   logic [7:0] press_cnt;
   logic [7:0] q[$];
   int         n_assert = 0;
   int         n_fail   = 0;
   int         low_cnt  = 0;

   ps2_scan_ctrl_if bus();

   ps2_scan_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .shift_flag (shift_flag),
      .ctrl_flag  (ctrl_flag),
      .press_cnt  (press_cnt),
      .ovf_sticky (ovf_sticky)
   );

   always #5 clk = ~clk;

   task automatic refresh();
      bus.kbd_ready = (q.size() != 0);
      bus.kbd_data  = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      refresh();
   endtask

   // FIFO model: head advances while the pop strobe is low
   always @(negedge clk) begin
      logic [7:0] dummy;
      if (!rst && !bus.kbd_nextdata_n) begin
         low_cnt = low_cnt + 1;
         if (q.size() != 0) begin
            dummy = q.pop_front();
            refresh();
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert = n_assert + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_evt(input string tag, input logic e, input logic b, input logic [7:0] c);
      int t = 0;
      while (!bus.evt_valid && t < 200) begin
         @(negedge clk);
         t = t + 1;
      end
      chk({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
      chk({tag, "_evt"}, 32'({bus.evt_ext, bus.evt_brk, bus.evt_code}), 32'({e, b, c}));
      bus.evt_ready = 1'b1;
      @(negedge clk);
      bus.evt_ready = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int t;
      bus.evt_ready    = 1'b0;
      bus.kbd_overflow = 1'b0;
      refresh();
      idle_cycles(2);
      chk("rst_nextdata_n", 32'(bus.kbd_nextdata_n), 32'd1);
      chk("rst_outputs", 32'({bus.evt_valid, bus.evt_ext, bus.evt_brk, bus.evt_code}), 32'd0);
      chk("rst_status", 32'({shift_flag, ctrl_flag, ovf_sticky, press_cnt}), 32'd0);
      rst = 1'b0;
      idle_cycles(2);

      // Make then break of 1C, with the first event's latency checked cycle by cycle
      low_cnt = 0;
      push(8'h1C); push(8'hF0); push(8'h1C);
      @(negedge clk);
      chk("lat_pop_low", 32'(bus.kbd_nextdata_n), 32'd0);
      @(negedge clk);
      chk("lat_pop_high", 32'({bus.kbd_nextdata_n, bus.evt_valid}), 32'b10);
      @(negedge clk);
      chk("lat_valid", 32'(bus.evt_valid), 32'd1);
      expect_evt("a_make", 1'b0, 1'b0, 8'h1C);
      expect_evt("a_brk", 1'b0, 1'b1, 8'h1C);
      chk("a_press_cnt", 32'(press_cnt), 32'd1);
      chk("a_pops", 32'(low_cnt), 32'd3);

      // Shift held across another key
      push(8'h12);
      expect_evt("b_shift", 1'b0, 1'b0, 8'h12);
      chk("b_shift_on", 32'(shift_flag), 32'd1);
      push(8'h1C);
      expect_evt("b_key", 1'b0, 1'b0, 8'h1C);
      chk("b_shift_still", 32'(shift_flag), 32'd1);
      push(8'hF0); push(8'h12);
      expect_evt("b_shift_brk", 1'b0, 1'b1, 8'h12);
      chk("b_shift_off", 32'(shift_flag), 32'd0);
      chk("b_press_cnt", 32'(press_cnt), 32'd3);

      // Right ctrl via E0 prefix
      push(8'hE0); push(8'h14);
      expect_evt("c_rctrl", 1'b1, 1'b0, 8'h14);
      chk("c_ctrl_on", 32'({ctrl_flag, shift_flag}), 32'b10);
      push(8'hE0); push(8'hF0); push(8'h14);
      expect_evt("c_rctrl_brk", 1'b1, 1'b1, 8'h14);
      chk("c_ctrl_off", 32'(ctrl_flag), 32'd0);
      chk("c_press_cnt", 32'(press_cnt), 32'd4);

      // Backpressure: no pops while an event waits
      push(8'h1C); push(8'h32); push(8'h21);
      t = 0;
      while (!bus.evt_valid && t < 50) begin @(negedge clk); t = t + 1; end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!bus.evt_valid || bus.evt_code != 8'h1C || !bus.kbd_nextdata_n) bad = bad + 1;
      end
      chk("d_stable", 32'(bad), 32'd0);
      chk("d_queued", 32'(q.size()), 32'd2);
      expect_evt("d_ev0", 1'b0, 1'b0, 8'h1C);
      expect_evt("d_ev1", 1'b0, 1'b0, 8'h32);
      expect_evt("d_ev2", 1'b0, 1'b0, 8'h21);
      chk("d_press_cnt", 32'(press_cnt), 32'd7);

      // Auto-repeat
      push(8'h1B); push(8'h1B); push(8'h1B); push(8'hF0); push(8'h1B);
      expect_evt("e_make0", 1'b0, 1'b0, 8'h1B);
`ifndef PS2_SCAN_TYPEMATIC_FILTER_EN
      expect_evt("e_make1", 1'b0, 1'b0, 8'h1B);
      expect_evt("e_make2", 1'b0, 1'b0, 8'h1B);
`endif
      expect_evt("e_brk", 1'b0, 1'b1, 8'h1B);
      idle_cycles(4);
      chk("e_no_extra", 32'({bus.evt_valid, 1'(q.size() != 0)}), 32'd0);
`ifdef PS2_SCAN_TYPEMATIC_FILTER_EN
      chk("e_press_cnt", 32'(press_cnt), 32'd8);
`else
      chk("e_press_cnt", 32'(press_cnt), 32'd10);
`endif

      // Overflow between F0 and the key clears the pending break
      chk("f_ovf_before", 32'(ovf_sticky), 32'd0);
      push(8'hF0);
      idle_cycles(6);
      bus.kbd_overflow = 1'b1;
      @(negedge clk);
      bus.kbd_overflow = 1'b0;
      push(8'h1C);
      expect_evt("f_resync", 1'b0, 1'b0, 8'h1C);
      chk("f_ovf_sticky", 32'(ovf_sticky), 32'd1);
`ifdef PS2_SCAN_TYPEMATIC_FILTER_EN
      chk("f_press_cnt", 32'(press_cnt), 32'd9);
`else
      chk("f_press_cnt", 32'(press_cnt), 32'd11);
`endif

      // Reset while popping, after a dangling E0
      push(8'hE0);
      idle_cycles(6);
      push(8'h1C);
      t = 0;
      while (bus.kbd_nextdata_n && t < 20) begin @(negedge clk); t = t + 1; end
      chk("g_in_pop", 32'(bus.kbd_nextdata_n), 32'd0);
      rst = 1'b1;
      #1;
      chk("g_rst_nextdata_n", 32'(bus.kbd_nextdata_n), 32'd1);
      chk("g_rst_outputs", 32'({bus.evt_valid, bus.evt_ext, bus.evt_brk, bus.evt_code}), 32'd0);
      chk("g_rst_status", 32'({shift_flag, ctrl_flag, ovf_sticky, press_cnt}), 32'd0);
      q.delete();
      refresh();
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(2);
      push(8'h1D);
      expect_evt("g_no_prefix", 1'b0, 1'b0, 8'h1D);
      chk("g_press_cnt", 32'(press_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
